bus_control_sequencer: RTL and testbench

//  Control unit for the shared 32-bit register-transfer bus datapath (R0-R15, HI, LO, ZHI/ZLO, PC, MAR/MDR, IR, Y).

---
 rtl/cpu_ctl_pkg.sv | 44 ++++
 rtl/ctl_timeout_counter.sv | 27 ++
 rtl/bus_control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_bus_control_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctl_pkg.sv
// Shared types and encodings for the bus control sequencer: state enum, opcodes,
// bus source indices and ctl_in bit positions.
package cpu_ctl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [4:0] SRC_HI  = 5'd16;
  localparam logic [4:0] SRC_LO  = 5'd17;
  localparam logic [4:0] SRC_ZHI = 5'd18;
  localparam logic [4:0] SRC_ZLO = 5'd19;
  localparam logic [4:0] SRC_PC  = 5'd20;
  localparam logic [4:0] SRC_MDR = 5'd21;

  localparam int CTL_PC  = 0;
  localparam int CTL_MAR = 1;
  localparam int CTL_MDR = 2;
  localparam int CTL_IR  = 3;
  localparam int CTL_Y   = 4;
  localparam int CTL_Z   = 5;
  localparam int CTL_LO  = 6;
  localparam int CTL_HI  = 7;

  localparam logic [1:0] FAULT_OPC = 2'b01;
  localparam logic [1:0] FAULT_ALU = 2'b10;

  function automatic logic opc_legal(input logic [4:0] opc);
    return opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_MUL, OPC_DIV};
  endfunction

  function automatic logic opc_multi(input logic [4:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

endpackage

// File: rtl/ctl_timeout_counter.sv
// Down-counter guarding the MUL/DIV wait; expire is the terminal-count compare
// qualified by enable, so it fires during the last permitted waiting cycle.
module ctl_timeout_counter #(
  parameter int LIMIT = 64,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (load)
      cnt <= W'(LIMIT);
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/bus_control_sequencer.sv
// Fetch/execute control FSM for the shared register-transfer bus datapath.
//  state | meaning
//  IDLE  | waiting for run with no fault
//  T0    | PC to bus, load MAR, start PC+1
//  T1    | PC+1 back to PC, wait for memory read ack
//  T2    | MDR to IR
//  T3    | latch fields, decode, Rb to Y
//  T4    | Rc to ALU; MUL/DIV waits on alu_ready
//  T5    | ZLO to Ra (or LO for MUL/DIV)
//  T6    | ZHI to HI (MUL/DIV only)
//  HALT  | absorbing until clr
module bus_control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int NUM_GPR     = 16,
  parameter int OPC_W       = 5,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run,
  input  logic [31:0]        ir,
  input  logic               mem_ack,
  input  logic               alu_ready,
  output logic [4:0]         bus_sel,
  output logic               bus_oe,
  output logic [NUM_GPR-1:0] gpr_in,
  output logic [7:0]         ctl_in,
  output logic [OPC_W-1:0]   alu_op,
  output logic               alu_start,
  output logic               inc_pc,
  output logic               mem_read,
  output logic               busy,
  output logic [1:0]         fault,
  output logic               halted
);

  state_t state, prev_state;
  logic [OPC_W-1:0] opc;
  logic [3:0] ra, rb, rc;
  logic entry, tmo_expire, tmo_en, unused_ir;

  logic [OPC_W-1:0] ir_opc;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  assign ir_opc    = ir[31 -: OPC_W];
  assign ir_ra     = ir[26:23];
  assign ir_rb     = ir[22:19];
  assign ir_rc     = ir[18:15];
  assign unused_ir = ^ir[14:0];

  // First cycle of a state; gates the one-shot PCin and alu_start.
  assign entry  = (state != prev_state);
  assign tmo_en = (state == ST_T4) && opc_multi(opc) && !alu_ready;

  ctl_timeout_counter #(.LIMIT(ALU_TIMEOUT)) u_tmo (
    .clk    (clk),
    .clr    (clr),
    .load   (state != ST_T4),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_IDLE;
      prev_state <= ST_IDLE;
      opc        <= '0;
      ra         <= '0;
      rb         <= '0;
      rc         <= '0;
      fault      <= '0;
      halted     <= 1'b0;
    end else begin
      prev_state <= state;
      case (state)
        ST_IDLE: if (run && fault == 2'b00) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (mem_ack) state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3: begin
          opc <= ir_opc;
          ra  <= ir_ra;
          rb  <= ir_rb;
          rc  <= ir_rc;
          if (opc_legal(ir_opc)) begin
            state <= ST_T4;
          end else if (ir_opc == OPC_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_IDLE;
            fault <= FAULT_OPC;
          end
        end
        ST_T4: begin
          if (!opc_multi(opc) || alu_ready) begin
            state <= ST_T5;
          end else if (tmo_expire) begin
            state <= ST_IDLE;
            fault <= FAULT_ALU;
          end
        end
        ST_T5:   state <= opc_multi(opc) ? ST_T6 : (run ? ST_T0 : ST_IDLE);
        ST_T6:   state <= run ? ST_T0 : ST_IDLE;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In T3 the fields are not latched yet, so Rb comes straight from ir.
  always_comb begin
    bus_oe    = 1'b0;
    bus_sel   = '0;
    gpr_in    = '0;
    ctl_in    = '0;
    alu_op    = '0;
    alu_start = 1'b0;
    inc_pc    = 1'b0;
    mem_read  = 1'b0;
    case (state)
      ST_T0: begin
        bus_oe = 1'b1;  bus_sel = SRC_PC;
        ctl_in[CTL_MAR] = 1'b1;
        ctl_in[CTL_Z]   = 1'b1;
        inc_pc = 1'b1;
      end
      ST_T1: begin
        bus_oe = 1'b1;  bus_sel = SRC_ZLO;
        mem_read = 1'b1;
        ctl_in[CTL_PC]  = entry;
        ctl_in[CTL_MDR] = mem_ack;
      end
      ST_T2: begin
        bus_oe = 1'b1;  bus_sel = SRC_MDR;
        ctl_in[CTL_IR] = 1'b1;
      end
      ST_T3: begin
        if (opc_legal(ir_opc)) begin
          bus_oe = 1'b1;  bus_sel = {1'b0, ir_rb};
          ctl_in[CTL_Y] = 1'b1;
        end
      end
      ST_T4: begin
        bus_oe = 1'b1;  bus_sel = {1'b0, rc};
        alu_op = opc;
        if (opc_multi(opc)) alu_start = entry;
        else ctl_in[CTL_Z] = 1'b1;
      end
      ST_T5: begin
        bus_oe = 1'b1;  bus_sel = SRC_ZLO;
        if (opc_multi(opc)) ctl_in[CTL_LO] = 1'b1;
        else gpr_in[ra] = 1'b1;
      end
      ST_T6: begin
        bus_oe = 1'b1;  bus_sel = SRC_ZHI;
        ctl_in[CTL_HI] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE) && (state != ST_HALT);

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Randomized bench: an instruction-level model expands each instruction into the
// per-cycle bus/enable trace the sequencer must produce, then replays and compares.
module tb_bus_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_ack, alu_ready;
  logic [31:0] ir;
  logic [4:0]  bus_sel;
  logic        bus_oe;
  logic [15:0] gpr_in;
  logic [7:0]  ctl_in;
  logic [4:0]  alu_op;
  logic        alu_start, inc_pc, mem_read, busy, halted;
  logic [1:0]  fault;

  bus_control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ack(mem_ack), .alu_ready(alu_ready),
    .bus_sel(bus_sel), .bus_oe(bus_oe), .gpr_in(gpr_in), .ctl_in(ctl_in), .alu_op(alu_op),
    .alu_start(alu_start), .inc_pc(inc_pc), .mem_read(mem_read), .busy(busy),
    .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, ack, rdy;
    logic [31:0] ir;
    logic        oe;
    logic [4:0]  sel;
    logic [15:0] gpr;
    logic [7:0]  ctl;
    logic [4:0]  aop;
    logic        start, inc, rd, busy;
    logic [1:0]  flt;
    logic        hlt;
  } cyc_t;

  cyc_t q[$];
  logic [1:0] m_fault = 2'b00;
  logic m_halted = 1'b0;
  logic m_idle = 1'b1;
  int n_chk = 0, n_pass = 0, cyc = 0;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
  localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, HLT = 5'b11011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
  endtask

  function automatic cyc_t blank(input logic r);
    cyc_t c;
    c = '{default: '0};
    c.ir   = $urandom;
    c.run  = r;
    c.busy = 1'b1;
    c.flt  = m_fault;
    c.hlt  = m_halted;
    return c;
  endfunction

  task automatic idle(input int n, input logic r);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(r);
      c.busy = 1'b0;
      q.push_back(c);
    end
  endtask

  // alu_d < 0 means alu_ready never arrives.
  task automatic gen(input logic [4:0] opc, input int ra, input int rb, input int rc,
                     input int ack_d, input int alu_d, input logic run_end);
    cyc_t c;
    logic multi, legal;
    multi = (opc == MUL) || (opc == DIV);
    legal = opc inside {ADD, SUB, AND_, OR_, MUL, DIV};
    if (m_idle) begin
      idle(1, 1'b1);
      m_idle = 1'b0;
    end
    c = blank(1'b1); c.oe = 1; c.sel = 5'd20; c.ctl = 8'h22; c.inc = 1; q.push_back(c);
    for (int k = 0; k <= ack_d; k++) begin
      c = blank(1'b1); c.oe = 1; c.sel = 5'd19; c.rd = 1;
      c.ack = (k == ack_d);
      c.ctl = {5'd0, c.ack, 1'b0, (k == 0)};
      q.push_back(c);
    end
    c = blank(run_end); c.oe = 1; c.sel = 5'd21; c.ctl = 8'h08; q.push_back(c);
    c = blank(run_end);
    c.ir = {opc, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    if (legal) begin c.oe = 1; c.sel = 5'(rb); c.ctl = 8'h10; end
    q.push_back(c);
    if (opc == HLT) begin m_halted = 1'b1; return; end
    if (!legal) begin m_fault = 2'b01; m_idle = 1'b1; return; end
    if (multi) begin
      for (int k = 0; k < 64; k++) begin
        c = blank(run_end); c.oe = 1; c.sel = 5'(rc); c.aop = opc;
        c.start = (k == 0);
        c.rdy = (k == alu_d);
        q.push_back(c);
        if (k == alu_d) break;
      end
      if (alu_d < 0 || alu_d > 63) begin m_fault = 2'b10; m_idle = 1'b1; return; end
    end else begin
      c = blank(run_end); c.oe = 1; c.sel = 5'(rc); c.aop = opc; c.ctl = 8'h20; q.push_back(c);
    end
    c = blank(run_end); c.oe = 1; c.sel = 5'd19;
    if (multi) c.ctl = 8'h40;
    else c.gpr = 16'(1) << ra;
    q.push_back(c);
    if (multi) begin
      c = blank(run_end); c.oe = 1; c.sel = 5'd18; c.ctl = 8'h80; q.push_back(c);
    end
    m_idle = !run_end;
  endtask

  task automatic play(input int n);
    cyc_t c;
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      c = q.pop_front();
      k++;
      @(posedge clk); #1;
      run = c.run; ir = c.ir; mem_ack = c.ack; alu_ready = c.rdy;
      @(negedge clk);
      cyc++;
      chk("bus",    32'({bus_oe, bus_sel}), 32'({c.oe, c.sel}));
      chk("gpr_in", 32'(gpr_in), 32'(c.gpr));
      chk("ctl_in", 32'(ctl_in), 32'(c.ctl));
      chk("alu",    32'({alu_op, alu_start}), 32'({c.aop, c.start}));
      chk("mem",    32'({inc_pc, mem_read}), 32'({c.inc, c.rd}));
      chk("status", 32'({busy, fault, halted}), 32'({c.busy, c.flt, c.hlt}));
      chk("gpr_onehot", 32'($countones(gpr_in) <= 1), 32'd1);
    end
    q.delete();
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr = 1'b1; run = 1'b0; mem_ack = 1'b0; alu_ready = 1'b0;
    #2;
    chk("rst_outputs", 32'({bus_oe, bus_sel, ctl_in, alu_op, alu_start, inc_pc, mem_read}), 32'd0);
    chk("rst_gpr", 32'(gpr_in), 32'd0);
    chk("rst_status", 32'({busy, fault, halted}), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    m_fault = 2'b00; m_halted = 1'b0; m_idle = 1'b1;
    q.delete();
  endtask

  initial begin
    logic [4:0] ops [6];
    logic [4:0] o;
    ops = '{ADD, SUB, AND_, OR_, MUL, DIV};
    clr = 1'b1; run = 1'b0; mem_ack = 1'b0; alu_ready = 1'b0; ir = '0;
    repeat (2) @(posedge clk);
    do_clr();

    // Directed: ADD R3,R1,R2; MUL R0,R4,R5 (ready 10 after start); SUB with slow ack, run dropped.
    gen(ADD, 3, 1, 2, 0, 0, 1'b1);
    gen(MUL, 0, 4, 5, 1, 10, 1'b1);
    gen(SUB, 7, 7, 7, 3, 0, 1'b0);
    idle(3, 1'b0);
    play(-1);

    for (int i = 0; i < 30; i++) begin
      if (m_idle && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b0);
      gen(ops[$urandom_range(0, 5)], $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 12),
          $urandom_range(0, 3) != 0);
      play(-1);
    end

    // Abort in the middle of a MUL wait.
    gen(MUL, 1, 2, 3, 0, -1, 1'b1);
    play(6);
    do_clr();
    idle(2, 1'b0);
    play(-1);

    gen(5'b11111, 1, 2, 3, $urandom_range(0, 3), 0, 1'b1);
    idle(3, 1'b1);
    play(-1);
    do_clr();

    do o = 5'($urandom_range(0, 31)); while (o inside {ADD, SUB, AND_, OR_, MUL, DIV, HLT});
    gen(o, 4, 5, 6, 0, 0, 1'b1);
    idle(2, 1'b1);
    play(-1);
    do_clr();

    gen(DIV, 2, 3, 4, 1, -1, 1'b1);
    idle(3, 1'b1);
    play(-1);
    do_clr();

    gen(HLT, 0, 0, 0, 2, 0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1, 1'($urandom_range(0, 1)));
    play(-1);
    do_clr();

    gen(OR_, 15, 0, 15, 0, 0, 1'b0);
    idle(2, 1'b0);
    play(-1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
